// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-read-port register file with pending scoreboard and bulk-clear engine
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           writeEnable,
    input  logic [ADDR_WIDTH-1:0]          writeAddress,
    input  logic [DATA_WIDTH-1:0]          writeData,
    input  logic                           reserveEnable,
    input  logic [ADDR_WIDTH-1:0]          reserveAddress,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0] readData,
    output logic [NUM_READ-1:0]            readPending,
    input  logic                           clearStart,
    output logic                           clearBusy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      pend_q;
    logic [DEPTH-1:0]      pend_d;
    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;

    logic wr_eff;
    logic rs_eff;

    // Writes and reserves only take effect in IDLE; register 0 is immune when hardwired
    always_comb begin
        wr_eff = (state_q == ST_IDLE) && writeEnable &&
                 !((ZERO_REG != 0) && (writeAddress == '0));
        rs_eff = (state_q == ST_IDLE) && reserveEnable &&
                 !((ZERO_REG != 0) && (reserveAddress == '0));
    end

    // Next-state: normal write/reserve in IDLE, one register per edge wiped in CLEAR
    always_comb begin
        mem_d   = mem_q;
        pend_d  = pend_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_eff) begin
                    mem_d[writeAddress]  = writeData;
                    pend_d[writeAddress] = 1'b0;
                end
                // Reserve is applied after the write so a new in-flight producer wins
                if (rs_eff) begin
                    pend_d[reserveAddress] = 1'b1;
                end
                cnt_d = '0;
                if (clearStart) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mem_d[cnt_q]  = '0;
                pend_d[cnt_q] = 1'b0;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous clear of the whole array
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pend_q  <= pend_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read ports: zero register first, then same-cycle write bypass, then storage
    always_comb begin
        readData    = '0;
        readPending = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            if ((ZERO_REG != 0) && (readAddress[k*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                readData[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                readPending[k]                       = 1'b0;
            end else if (wr_eff && (writeAddress == readAddress[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                readData[k*DATA_WIDTH +: DATA_WIDTH] = writeData;
                readPending[k] = rs_eff &&
                                 (reserveAddress == readAddress[k*ADDR_WIDTH +: ADDR_WIDTH]);
            end else begin
                readData[k*DATA_WIDTH +: DATA_WIDTH] =
                    mem_q[readAddress[k*ADDR_WIDTH +: ADDR_WIDTH]];
                readPending[k] = pend_q[readAddress[k*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

    // Busy flag is simply the CLEAR state, so reset drops it without a clock
    always_comb begin
        clearBusy = (state_q == ST_CLEAR);
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed scoreboard bench for reg_file_sb
module tb_reg_file_sb;

    logic        CLK;
    logic        RST_N;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [9:0]  rd_addr;
    logic [63:0] rdata;
    logic [1:0]  rpend;
    logic        cs;
    logic        busy;
    logic [63:0] rdata_z;
    logic [1:0]  rpend_z;
    logic        busy_z;

    int n_vec;
    int n_err;
    int cnt;
    int guard;

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] data;
        logic        pend;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .writeEnable(we), .writeAddress(wa), .writeData(wd),
        .reserveEnable(re), .reserveAddress(ra),
        .readAddress(rd_addr), .readData(rdata), .readPending(rpend),
        .clearStart(cs), .clearBusy(busy)
    );

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(0)) dut_nz (
        .CLK(CLK), .RST_N(RST_N),
        .writeEnable(we), .writeAddress(wa), .writeData(wd),
        .reserveEnable(re), .reserveAddress(ra),
        .readAddress(rd_addr), .readData(rdata_z), .readPending(rpend_z),
        .clearStart(cs), .clearBusy(busy_z)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_read(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic push(input int d, input int p, input logic [31:0] data,
                        input logic pend, input string tag);
        exp_t e;
        e.dut = d; e.port = p; e.data = data; e.pend = pend; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] od;
        logic        op;
        #1;
        while (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            od = (e.dut == 0) ? rdata[e.port*32 +: 32] : rdata_z[e.port*32 +: 32];
            op = (e.dut == 0) ? rpend[e.port] : rpend_z[e.port];
            n_vec++;
            assert (od === e.data) else begin
                n_err++;
                $error("FAIL %s data: got %h expected %h", e.tag, od, e.data);
            end
            n_vec++;
            assert (op === e.pend) else begin
                n_err++;
                $error("FAIL %s pending: got %b expected %b", e.tag, op, e.pend);
            end
        end
    endtask

    task automatic chk_busy(input logic exp, input string tag);
        n_vec++;
        assert (busy === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, busy, exp);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        RST_N = 1'b0; we = 1'b0; wa = '0; wd = '0; re = 1'b0; ra = '0; cs = 1'b0;
        set_read(5'd5, 5'd7);

        // reset state
        #1;
        chk_busy(1'b0, "reset_busy");
        push(0, 0, 32'h0, 1'b0, "reset_r5");
        push(0, 1, 32'h0, 1'b0, "reset_r7");
        drain();
        tick();
        RST_N = 1'b1;

        // write reg 5, reserve reg 7
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; re = 1'b1; ra = 5'd7;
        tick();
        we = 1'b0; re = 1'b0;
        push(0, 0, 32'hDEADBEEF, 1'b0, "post_reset_r5");
        push(0, 1, 32'h0, 1'b1, "post_reset_r7");
        drain();

        // same-cycle bypass on port 1
        we = 1'b1; wa = 5'd3; wd = 32'h12345678;
        set_read(5'd5, 5'd3);
        push(0, 0, 32'hDEADBEEF, 1'b0, "bypass_p0");
        push(0, 1, 32'h12345678, 1'b0, "bypass_p1");
        drain();
        tick();
        we = 1'b0;
        set_read(5'd3, 5'd3);
        push(0, 0, 32'h12345678, 1'b0, "stored_r3_p0");
        push(0, 1, 32'h12345678, 1'b0, "stored_r3_p1");
        drain();

        // zero register: hardwired instance ignores, plain instance stores
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; re = 1'b1; ra = 5'd0;
        set_read(5'd0, 5'd0);
        push(0, 0, 32'h0, 1'b0, "zero_byp_p0");
        push(0, 1, 32'h0, 1'b0, "zero_byp_p1");
        push(1, 0, 32'hFFFFFFFF, 1'b1, "nz_byp_r0");
        drain();
        tick();
        we = 1'b0; re = 1'b0;
        push(0, 0, 32'h0, 1'b0, "zero_st_p0");
        push(0, 1, 32'h0, 1'b0, "zero_st_p1");
        push(1, 1, 32'hFFFFFFFF, 1'b1, "nz_st_r0");
        drain();

        // reserve/write collision on reg 9
        re = 1'b1; ra = 5'd9;
        tick();
        re = 1'b0;
        set_read(5'd9, 5'd9);
        push(0, 0, 32'h0, 1'b1, "resv_r9");
        drain();
        we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5; re = 1'b1; ra = 5'd9;
        push(0, 1, 32'hA5A5A5A5, 1'b1, "coll_byp_r9");
        drain();
        tick();
        re = 1'b0; we = 1'b0;
        push(0, 0, 32'hA5A5A5A5, 1'b1, "coll_st_r9");
        drain();
        we = 1'b1;
        push(0, 0, 32'hA5A5A5A5, 1'b0, "wonly_byp_r9");
        drain();
        tick();
        we = 1'b0;
        push(0, 1, 32'hA5A5A5A5, 1'b0, "wonly_st_r9");
        drain();

        // fill every register, reserve those with index % 4 == 1
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'hC0DE0000 + 32'(i) + 32'd1;
            re = ((i % 4) == 1); ra = 5'(i);
            tick();
        end
        we = 1'b0; re = 1'b0;
        set_read(5'd17, 5'd18);
        push(0, 0, 32'hC0DE0012, 1'b1, "fill_r17");
        push(0, 1, 32'hC0DE0013, 1'b0, "fill_r18");
        drain();

        // bulk clear: count busy cycles, inject a write that must be dropped
        cs = 1'b1;
        tick();
        cs = 1'b0;
        cnt = 0; guard = 0;
        while (busy && guard < 100) begin
            cnt++; guard++;
            if (cnt == 6) begin
                we = 1'b1; wa = 5'd18; wd = 32'h00000BAD;
                set_read(5'd3, 5'd18);
                push(0, 0, 32'h0, 1'b0, "clr_done_r3");
                push(0, 1, 32'hC0DE0013, 1'b0, "clr_nobyp_r18");
                drain();
            end
            tick();
            we = 1'b0;
        end
        n_vec++;
        assert (cnt === 32) else begin
            n_err++;
            $error("FAIL clear_busy_cycles: got %0d expected %0d", cnt, 32);
        end
        // first write after clear is accepted immediately
        we = 1'b1; wa = 5'd12; wd = 32'h0000600D;
        tick();
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_read(5'(i), 5'(31 - i));
            push(0, 0, (i == 12) ? 32'h600D : 32'h0, 1'b0, "post_clr_p0");
            push(0, 1, ((31 - i) == 12) ? 32'h600D : 32'h0, 1'b0, "post_clr_p1");
            drain();
        end

        // reset in the middle of a clear
        we = 1'b1; wa = 5'd20; wd = 32'h55;
        tick();
        we = 1'b0; re = 1'b1; ra = 5'd25;
        tick();
        re = 1'b0; cs = 1'b1;
        tick();
        cs = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk_busy(1'b1, "mid_clear_busy");
        RST_N = 1'b0;
        #1;
        chk_busy(1'b0, "async_reset_busy");
        set_read(5'd20, 5'd25);
        push(0, 0, 32'h0, 1'b0, "rst_mid_r20");
        push(0, 1, 32'h0, 1'b0, "rst_mid_r25");
        drain();
        RST_N = 1'b1;
        we = 1'b1; wa = 5'd4; wd = 32'h77;
        tick();
        we = 1'b0;
        set_read(5'd4, 5'd20);
        push(0, 0, 32'h77, 1'b0, "rst_first_wr_r4");
        push(0, 1, 32'h0, 1'b0, "rst_after_r20");
        drain();
        chk_busy(1'b0, "final_idle_busy");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read-port register file with an integrated scoreboard and a sequential bulk-clear engine. It is the next-generation register file for the single-cycle MIPS datapath and its pipelined follow-on. It provides:
- configurable width, depth and read-port count;
- write-to-read bypass;
- an optional hardwired zero register;
- per-register pending bits, so issue logic can detect read-after-write hazards.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers
- NUM_READ, 2, number of combinational read ports (≥1)
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes/reserves

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST_N  input  1  asynchronous, active-low reset
- writeEnable  input  1  write strobe
- writeAddress  input  ADDR_WIDTH  write target
- writeData  input  DATA_WIDTH  write value
- reserveEnable  input  1  mark a register as pending (producer issued)
- reserveAddress  input  ADDR_WIDTH  register to reserve
- readAddress  input  NUM_READ*ADDR_WIDTH  flattened; port k = [k*ADDR_WIDTH +: ADDR_WIDTH]
- readData  output  NUM_READ*DATA_WIDTH  flattened; port k = [k*DATA_WIDTH +: DATA_WIDTH]
- readPending  output  NUM_READ  port k scoreboard bit of its addressed register
- clearStart  input  1  request bulk clear of all registers and pending bits
- clearBusy  output  1  high while bulk clear in progress

## Operation
- **Reset (RST_N low, asynchronous):**
  - all registers = 0, all pending bits = 0;
  - FSM = IDLE, clear counter = 0, clearBusy = 0.
- **FSM states:** IDLE, CLEAR.
  - IDLE -> CLEAR on a sampled clearStart.
  - CLEAR -> IDLE after the edge that clears index DEPTH-1.
  - clearStart is ignored in CLEAR.
- **Write (IDLE only):**
  - at the edge, if writeEnable is high, reg[writeAddress] <= writeData and pending[writeAddress] <= 0;
  - suppressed when ZERO_REG=1 and writeAddress=0.
- **Reserve (IDLE only):**
  - at the edge, if reserveEnable is high, pending[reserveAddress] <= 1;
  - suppressed for address 0 when ZERO_REG=1.
  - Reserve and write to the same address in the same cycle: reserve wins, so the data is written and the pending bit ends at 1 (a new producer is in flight).
- **Read port k (combinational), evaluated in priority order:**
  1. ZERO_REG=1 and address 0 -> data 0, pending 0.
  2. FSM IDLE, writeEnable high and an effective write to the same address -> data = writeData (bypass); pending = 1 only if a same-cycle reserve hits that address, else 0.
  3. Otherwise -> stored data and stored pending bit.
- All read ports are independent; identical addresses on several ports are legal.
- **CLEAR:**
  - a counter walks 0..DEPTH-1, one register per edge, writing 0 to the register and its pending bit;
  - writeEnable and reserveEnable are ignored (dropped, not queued);
  - reads return stored values with no bypass.

## Timing
- Write latency: data is visible through the bypass in the same cycle and in storage from the next cycle.
- Pending bit latency: set or cleared at the edge; readPending reflects the new value after that edge, except for the bypass rule above.
- Bulk clear, with clearStart sampled at edge N:
  - clearBusy is high from after edge N until after edge N+DEPTH;
  - register i is cleared at edge N+1+i;
  - total DEPTH cycles;
  - the first new write is accepted at edge N+DEPTH+1.
- clearStart held high continuously: clears restart back-to-back; each pass returns to IDLE for exactly one edge, and that edge samples clearStart again.
- Reset asserted mid-clear: immediate IDLE, all state zero, clearBusy = 0 with no clock needed.
- Counter wrap: the counter is ADDR_WIDTH bits; reaching DEPTH-1 ends CLEAR and the counter returns to 0.

## Test plan
- **Reset:** after reset, write reg 5 = 0xDEADBEEF, reserve reg 7. Read ports [5,7] -> 0xDEADBEEF/pending 0, 0x00000000/pending 1.
- **Bypass:** in the same cycle, write reg 3 = 0x12345678 and read port 1 addr 3 -> readData port 1 = 0x12345678 combinationally. Next cycle, a stored read also returns 0x12345678.
- **Zero register:** with ZERO_REG=1, write reg 0 = 0xFFFFFFFF and reserve reg 0 -> all ports reading 0 return 0 with pending 0. With ZERO_REG=0 the same write reads back 0xFFFFFFFF.
- **Reserve/write collision:** reserve reg 9, then next cycle write reg 9 = 0xA5A5A5A5 while reserving reg 9 again -> data 0xA5A5A5A5, pending 1. A following write-only cycle clears pending to 0.
- **Bulk clear:** fill all 32 registers with nonzero values and reserve several; pulse clearStart -> clearBusy high exactly 32 cycles. A write issued during busy is dropped. Afterwards every register reads 0 with pending 0.
- **Reset mid-clear:** assert RST_N low at clear index 10 -> clearBusy drops asynchronously. After release, all registers read 0 and a write is accepted at the first edge.
